// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing, strobes and perf counters.
// Optional ILLEGAL_TRAP_EN: unknown opcodes park the FSM in TRAP with a sticky illegal_o flag.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             halt_i,
  input  logic [6:0]       opcode_i,
  input  logic             zero_i,
  input  logic             imem_ready_i,
  input  logic             dmem_ready_i,
  output logic             iread_o,
  output logic             irwrite_o,
  output logic             pcwrite_o,
  output logic             pcsrc_o,
  output logic             alusrc_a_o,
  output logic [1:0]       alusrc_b_o,
  output logic [1:0]       aluop_o,
  output logic             memread_o,
  output logic             memwrite_o,
  output logic             memtoreg_o,
  output logic             regwrite_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] instret_o,
  output logic [CNT_W-1:0] cycle_o,
  output logic             illegal_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic             retire;
  logic             legal_op;

  assign legal_op = opcode_i inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH};

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
`endif

  // NOTE: state is written with <= so every flop samples the pre-edge values of its peers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
      cycle_q   <= '0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
      cycle_q   <= cycle_d;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  // Next state plus the retire pulse that feeds instret in the instruction's final cycle.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a variable unassigned (no latches).
    state_d = state_q;
    retire  = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    unique case (state_q)
      S_FETCH:  if (!halt_i && imem_ready_i) state_d = S_DECODE;
      S_DECODE: begin
        if (legal_op) begin
          state_d = S_EXEC;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          state_d   = S_TRAP;
          illegal_d = 1'b1;
`else
          state_d = S_FETCH;
          retire  = 1'b1;
`endif
        end
      end
      S_EXEC: begin
        if (opcode_i == OP_R || opcode_i == OP_I) begin
          state_d = S_WB;
        end else if (opcode_i == OP_LOAD || opcode_i == OP_STORE) begin
          state_d = S_MEM;
        end else begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_MEM: begin
        if (dmem_ready_i) begin
          if (opcode_i == OP_LOAD) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
    instret_d = instret_q + CNT_W'(retire);
    cycle_d   = cycle_q + CNT_W'(1);
  end

  // Strobe decode; reset gates everything so a mid-instruction reset drops requests at once.
  always_comb begin
    iread_o    = 1'b0;
    irwrite_o  = 1'b0;
    pcwrite_o  = 1'b0;
    pcsrc_o    = 1'b0;
    alusrc_a_o = 1'b0;
    alusrc_b_o = 2'b00;
    aluop_o    = 2'b00;
    memread_o  = 1'b0;
    memwrite_o = 1'b0;
    memtoreg_o = 1'b0;
    regwrite_o = 1'b0;
    if (!rst_i) begin
      unique case (state_q)
        S_FETCH: begin
          if (!halt_i) begin
            iread_o = 1'b1;
            if (imem_ready_i) begin
              irwrite_o  = 1'b1;
              pcwrite_o  = 1'b1;
              alusrc_b_o = 2'b01;
            end
          end
        end
        S_DECODE: alusrc_b_o = 2'b11;
        S_EXEC: begin
          alusrc_a_o = 1'b1;
          if (opcode_i == OP_R) begin
            aluop_o = 2'b10;
          end else if (opcode_i == OP_I) begin
            alusrc_b_o = 2'b10;
            aluop_o    = 2'b10;
          end else if (opcode_i == OP_LOAD || opcode_i == OP_STORE) begin
            alusrc_b_o = 2'b10;
          end else if (opcode_i == OP_BRANCH) begin
            aluop_o = 2'b01;
            if (zero_i) begin
              pcwrite_o = 1'b1;
              pcsrc_o   = 1'b1;
            end
          end
        end
        S_MEM: begin
          memread_o  = (opcode_i == OP_LOAD);
          memwrite_o = (opcode_i == OP_STORE);
        end
        S_WB: begin
          regwrite_o = 1'b1;
          memtoreg_o = (opcode_i == OP_LOAD);
        end
        default: ;
      endcase
    end
  end

  assign state_o   = state_q;
  assign instret_o = instret_q;
  assign cycle_o   = cycle_q;
`ifdef ILLEGAL_TRAP_EN
  assign illegal_o = illegal_q;
`else
  assign illegal_o = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: R, load with waits, branches, halt, async reset mid-store,
// and unknown opcode (trap or NOP depending on ILLEGAL_TRAP_EN).
module tb_multicycle_ctrl;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        halt_i;
  logic [6:0]  opcode_i;
  logic        zero_i;
  logic        imem_ready_i;
  logic        dmem_ready_i;
  logic        iread_o, irwrite_o, pcwrite_o, pcsrc_o, alusrc_a_o;
  logic [1:0]  alusrc_b_o, aluop_o;
  logic        memread_o, memwrite_o, memtoreg_o, regwrite_o;
  logic [2:0]  state_o;
  logic [31:0] instret_o, cycle_o;
  logic        illegal_o;

  int checks   = 0;
  int failures = 0;
  int rd_cnt;

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .halt_i(halt_i), .opcode_i(opcode_i), .zero_i(zero_i),
    .imem_ready_i(imem_ready_i), .dmem_ready_i(dmem_ready_i),
    .iread_o(iread_o), .irwrite_o(irwrite_o), .pcwrite_o(pcwrite_o), .pcsrc_o(pcsrc_o),
    .alusrc_a_o(alusrc_a_o), .alusrc_b_o(alusrc_b_o), .aluop_o(aluop_o),
    .memread_o(memread_o), .memwrite_o(memwrite_o), .memtoreg_o(memtoreg_o),
    .regwrite_o(regwrite_o), .state_o(state_o), .instret_o(instret_o), .cycle_o(cycle_o),
    .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(negedge clk_i);
  endtask

  initial begin
    rst_i = 1'b1; halt_i = 1'b0; opcode_i = OP_R; zero_i = 1'b0;
    imem_ready_i = 1'b1; dmem_ready_i = 1'b1;
    #2;
    check("rst_state", state_o, 0);
    check("rst_iread_forced", iread_o, 0);
    check("rst_instret", instret_o, 0);
    check("rst_cycle", cycle_o, 0);
    check("rst_illegal", illegal_o, 0);

    // 1: R-type, states 0,1,2,4,0
    tick(); rst_i = 1'b0; #1;
    check("r_fetch_state", state_o, 0);
    check("r_fetch_irwrite", irwrite_o, 1);
    check("r_fetch_pcwrite", pcwrite_o, 1);
    check("r_fetch_b", alusrc_b_o, 2'b01);
    check("r_fetch_regwrite", regwrite_o, 0);
    tick(); #1;
    check("r_dec_state", state_o, 1);
    check("r_dec_b", alusrc_b_o, 2'b11);
    tick(); #1;
    check("r_exec_state", state_o, 2);
    check("r_exec_a", alusrc_a_o, 1);
    check("r_exec_aluop", aluop_o, 2'b10);
    check("r_exec_regwrite", regwrite_o, 0);
    tick(); #1;
    check("r_wb_state", state_o, 4);
    check("r_wb_regwrite", regwrite_o, 1);
    check("r_wb_memtoreg", memtoreg_o, 0);
    check("r_wb_instret", instret_o, 0);
    tick(); #1;
    check("r_done_state", state_o, 0);
    check("r_done_instret", instret_o, 1);
    check("r_done_cycle", cycle_o, 4);

    // 2: LOAD with dmem_ready low for 3 MEM cycles
    opcode_i = OP_LOAD; dmem_ready_i = 1'b0;
    tick(); #1;
    check("ld_dec_state", state_o, 1);
    check("ld_dec_memread", memread_o, 0);
    tick(); #1;
    check("ld_exec_state", state_o, 2);
    check("ld_exec_b", alusrc_b_o, 2'b10);
    check("ld_exec_aluop", aluop_o, 2'b00);
    rd_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) dmem_ready_i = 1'b1;
      #1;
      check("ld_mem_state", state_o, 3);
      if (memread_o === 1'b1) rd_cnt++;
    end
    check("ld_memread_cycles", rd_cnt, 4);
    tick(); #1;
    check("ld_wb_state", state_o, 4);
    check("ld_wb_memtoreg", memtoreg_o, 1);
    check("ld_wb_memread", memread_o, 0);
    tick(); #1;
    check("ld_done_state", state_o, 0);
    check("ld_done_instret", instret_o, 2);
    check("ld_done_cycle", cycle_o, 12);

    // 3: branch taken then not taken
    opcode_i = OP_BRANCH; zero_i = 1'b1;
    tick(); #1;
    tick(); #1;
    check("br1_exec_state", state_o, 2);
    check("br1_pcwrite", pcwrite_o, 1);
    check("br1_pcsrc", pcsrc_o, 1);
    check("br1_aluop", aluop_o, 2'b01);
    tick(); #1;
    check("br1_done_state", state_o, 0);
    check("br1_instret", instret_o, 3);
    zero_i = 1'b0;
    tick(); #1;
    tick(); #1;
    check("br0_exec_state", state_o, 2);
    check("br0_pcwrite", pcwrite_o, 0);
    tick(); #1;
    check("br0_instret", instret_o, 4);

    // 4: halt in FETCH for 5 cycles, then resume with an imem wait and a store
    halt_i = 1'b1; #1;
    check("halt_iread", iread_o, 0);
    check("halt_irwrite", irwrite_o, 0);
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      check("halt_state", state_o, 0);
    end
    check("halt_instret", instret_o, 4);
    check("halt_cycle", cycle_o, 23);
    halt_i = 1'b0; imem_ready_i = 1'b0; opcode_i = OP_STORE; dmem_ready_i = 1'b1; #1;
    check("iwait_iread", iread_o, 1);
    check("iwait_irwrite", irwrite_o, 0);
    check("iwait_pcwrite", pcwrite_o, 0);
    tick(); imem_ready_i = 1'b1; #1;
    check("st_fetch_state", state_o, 0);
    check("st_fetch_irwrite", irwrite_o, 1);
    tick(); #1;
    check("st_dec_state", state_o, 1);
    tick(); #1;
    check("st_exec_b", alusrc_b_o, 2'b10);
    tick(); #1;
    check("st_mem_state", state_o, 3);
    check("st_mem_memwrite", memwrite_o, 1);
    check("st_mem_memread", memread_o, 0);
    tick(); #1;
    check("st_done_state", state_o, 0);
    check("st_done_instret", instret_o, 5);

    // 6: async reset while a store waits in MEM
    dmem_ready_i = 1'b0;
    tick(); #1;
    tick(); #1;
    tick(); #1;
    tick(); #1;
    check("rs_mem_state", state_o, 3);
    check("rs_mem_memwrite", memwrite_o, 1);
    check("rs_mem_instret", instret_o, 5);
    #2; rst_i = 1'b1; dmem_ready_i = 1'b1; #1;
    check("rs_memwrite_drop", memwrite_o, 0);
    check("rs_state", state_o, 0);
    check("rs_instret", instret_o, 0);
    check("rs_cycle", cycle_o, 0);
    tick(); rst_i = 1'b0; opcode_i = 7'h7F; #1;
    check("rs_rel_state", state_o, 0);
    check("rs_rel_memwrite", memwrite_o, 0);
    check("rs_rel_iread", iread_o, 1);

    // 5: unknown opcode 7F
    tick(); #1;
    check("ill_dec_state", state_o, 1);
    tick(); #1;
`ifdef ILLEGAL_TRAP_EN
    check("ill_trap_state", state_o, 7);
    check("ill_flag", illegal_o, 1);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      check("ill_trap_hold", state_o, 7);
      check("ill_trap_iread", iread_o, 0);
    end
    check("ill_trap_instret", instret_o, 0);
    rst_i = 1'b1; #1;
    check("ill_rst_state", state_o, 0);
    check("ill_rst_flag", illegal_o, 0);
    tick(); rst_i = 1'b0;
`else
    check("ill_nop_state", state_o, 0);
    check("ill_nop_instret", instret_o, 1);
    check("ill_nop_flag", illegal_o, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
